// File: rtl/pifctl_regbank_pkg.sv
// Shared register map and read sub-address helpers for the PIF control register bank.
// Write and read addresses share the XI_PRWA space; sub-addresses follow the scratch count.
package pifctl_regbank_pkg;

  localparam int W_MISC     = 1;
  localparam int W_MASK     = 2;
  localparam int W_STATUS   = 3;
  localparam int R_ID       = 4;
  localparam int W_SCR_BASE = 8;  // room for up to 8 scratch registers at 8..15

  function automatic int sub_misc(input int num_scr);
    return num_scr + 1;
  endfunction

  function automatic int sub_status(input int num_scr);
    return num_scr + 2;
  endfunction

  function automatic int sub_mask(input int num_scr);
    return num_scr + 3;
  endfunction

endpackage

// File: rtl/pifctl_rdpipe.sv
// Byte-wide delay line with asynchronous active-low reset; DEPTH of 0 is a plain wire.
module pifctl_rdpipe #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  output logic [7:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign q = d;
  end else begin : g_regs
    logic [7:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/pifctl_regbank.sv
// PIF control register bank: scratch, misc, sticky event status with W1C/mask/irq, pipelined readback.
// Optional PIFCTL_RDCLR_EN: a completed host read of the status byte clears the bits it returned.
module pifctl_regbank
  import pifctl_regbank_pkg::*;
#(
  parameter int          XA_W      = 4,
  parameter int          SUBA_W    = 4,
  parameter int          DATA_W    = 6,
  parameter int          NUM_SCR   = 2,
  parameter int          MISC_W    = 4,
  parameter int          NUM_EVT   = 4,
  parameter int          RD_STAGES = 3,
  parameter logic [7:0]  ID_BYTE   = 8'h50
) (
  input  logic              xclk,
  input  logic              sys_rst,
  input  logic              XI_PWr,
  input  logic [XA_W-1:0]   XI_PRWA,
  input  logic              XI_PRdFinished,
  input  logic [SUBA_W-1:0] XI_PRdSubA,
  input  logic [DATA_W-1:0] XI_PD,
  input  logic [NUM_EVT-1:0] evt_in,
  output logic [7:0]        XO,
  output logic [MISC_W-1:0] MiscReg,
  output logic              irq
);

  localparam logic [XA_W-1:0]   A_MISC   = XA_W'(W_MISC);
  localparam logic [XA_W-1:0]   A_MASK   = XA_W'(W_MASK);
  localparam logic [XA_W-1:0]   A_STATUS = XA_W'(W_STATUS);
  localparam logic [XA_W-1:0]   A_RID    = XA_W'(R_ID);
  localparam logic [SUBA_W-1:0] S_MISC   = SUBA_W'(sub_misc(NUM_SCR));
  localparam logic [SUBA_W-1:0] S_STATUS = SUBA_W'(sub_status(NUM_SCR));
  localparam logic [SUBA_W-1:0] S_MASK   = SUBA_W'(sub_mask(NUM_SCR));

  logic [DATA_W-1:0]  scr [NUM_SCR];
  logic [MISC_W-1:0]  misc;
  logic [NUM_EVT-1:0] mask, status, status_next, evt_q, rise, clr;

  // Read pipeline state: stage1 snapshot, stage2 selected byte, stage3 R_ID gate.
  logic [SUBA_W-1:0]  s1;
  logic               s1_hit, s2_hit;
  logic [DATA_W-1:0]  s1_scr [NUM_SCR];
  logic [MISC_W-1:0]  s1_misc;
  logic [NUM_EVT-1:0] s1_status, s1_mask;
  logic [7:0]         sub_byte, sub_out, reg_out;

`ifdef PIFCTL_RDCLR_EN
  logic [NUM_EVT-1:0] rd_clr;
  assign rd_clr = (XI_PRdFinished && XI_PRWA == A_RID && s1_hit && s1 == S_STATUS)
                  ? s1_status : '0;
`else
  logic unused_rdfin;
  assign unused_rdfin = XI_PRdFinished;
`endif

  // NOTE: combinational blocks assign every output a default first so no path infers a latch.
  always_comb begin
    rise = evt_in & ~evt_q;
    clr  = '0;
    if (XI_PWr && XI_PRWA == A_STATUS) clr = XI_PD[NUM_EVT-1:0];
`ifdef PIFCTL_RDCLR_EN
    clr = clr | rd_clr;
`endif
    status_next = (status & ~clr) | rise;  // a same-cycle rise beats any clear
  end

  // NOTE: all state updates are non-blocking so each flop samples pre-edge values.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      // NOTE: the scratch array is a few flops, not a RAM, so it is reset like any register.
      for (int k = 0; k < NUM_SCR; k++) scr[k] <= '0;
      misc    <= '0;
      mask    <= '0;
      status  <= '0;
      evt_q   <= '0;
      MiscReg <= '0;
      irq     <= 1'b0;
    end else begin
      evt_q   <= evt_in;
      status  <= status_next;
      irq     <= |(status_next & mask);
      MiscReg <= misc;
      if (XI_PWr) begin
        for (int k = 0; k < NUM_SCR; k++)
          if (XI_PRWA == XA_W'(W_SCR_BASE + k)) scr[k] <= XI_PD;
        if (XI_PRWA == A_MISC) misc <= XI_PD[MISC_W-1:0];
        if (XI_PRWA == A_MASK) mask <= XI_PD[NUM_EVT-1:0];
      end
    end
  end

  always_comb begin
    sub_byte = {4'h6, 4'(s1)};
    if (s1 == '0) sub_byte = ID_BYTE;
    for (int k = 0; k < NUM_SCR; k++)
      if (s1 == SUBA_W'(k + 1)) sub_byte = {2'b01, 6'(s1_scr[k])};
    if (s1 == S_MISC)   sub_byte = {4'h5, 4'(s1_misc)};
    if (s1 == S_STATUS) sub_byte = 8'(s1_status);
    if (s1 == S_MASK)   sub_byte = 8'(s1_mask);
  end

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      s1        <= '0;
      s1_hit    <= 1'b0;
      for (int k = 0; k < NUM_SCR; k++) s1_scr[k] <= '0;
      s1_misc   <= '0;
      s1_status <= '0;
      s1_mask   <= '0;
      sub_out   <= '0;
      s2_hit    <= 1'b0;
      reg_out   <= '0;
    end else begin
      s1        <= XI_PRdSubA;
      s1_hit    <= (XI_PRWA == A_RID);
      for (int k = 0; k < NUM_SCR; k++) s1_scr[k] <= scr[k];
      s1_misc   <= misc;
      s1_status <= status;
      s1_mask   <= mask;
      sub_out   <= sub_byte;
      s2_hit    <= s1_hit;
      reg_out   <= s2_hit ? sub_out : 8'h00;
    end
  end

  pifctl_rdpipe #(.DEPTH(RD_STAGES - 1)) u_tail (
    .clk   (xclk),
    .rst_n (sys_rst),
    .d     (reg_out),
    .q     (XO)
  );

endmodule

// File: tb/tb_pifctl_regbank.sv
// Scoreboard bench for pifctl_regbank: stimulus queues expected XO/irq/MiscReg values with a due cycle,
// and a negedge monitor compares whatever falls due.
module tb_pifctl_regbank;
  import pifctl_regbank_pkg::*;

  localparam logic [3:0] A_RID  = 4'(R_ID);
  localparam logic [3:0] A_IDLE = 4'h0;
  localparam logic [3:0] S_STAT = 4'(sub_status(2));

  typedef enum int {K_XO, K_IRQ, K_MISC} kind_e;
  typedef struct {
    int         due;
    kind_e      kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic       xclk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       XI_PWr = 1'b0;
  logic [3:0] XI_PRWA = '0;
  logic       XI_PRdFinished = 1'b0;
  logic [3:0] XI_PRdSubA = '0;
  logic [5:0] XI_PD = '0;
  logic [3:0] evt_in = '0;
  logic [7:0] XO;
  logic [3:0] MiscReg;
  logic       irq;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  pifctl_regbank dut (
    .xclk           (xclk),
    .sys_rst        (sys_rst),
    .XI_PWr         (XI_PWr),
    .XI_PRWA        (XI_PRWA),
    .XI_PRdFinished (XI_PRdFinished),
    .XI_PRdSubA     (XI_PRdSubA),
    .XI_PD          (XI_PD),
    .evt_in         (evt_in),
    .XO             (XO),
    .MiscReg        (MiscReg),
    .irq            (irq)
  );

  always #5 xclk = ~xclk;
  always @(posedge xclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge xclk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          K_XO:    check(sb[i].name, XO, sb[i].exp);
          K_IRQ:   check(sb[i].name, {7'b0, irq}, sb[i].exp);
          default: check(sb[i].name, {4'b0, MiscReg}, sb[i].exp);
        endcase
        sb.delete(i);
      end
    end
  end

  task automatic push(input kind_e kind, input int due, input logic [7:0] exp, input string name);
    exp_t e;
    e.due = due; e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge xclk);
    #1;
  endtask

  task automatic rd(input logic [3:0] sub, input logic [7:0] exp, input string name);
    XI_PRWA = A_RID;
    XI_PRdSubA = sub;
    push(K_XO, cyc + 5, exp, name);
    step();
  endtask

  task automatic wr(input int addr, input logic [5:0] data);
    XI_PWr = 1'b1;
    XI_PRWA = 4'(addr);
    XI_PD = data;
    step();
    XI_PWr = 1'b0;
    XI_PRWA = A_IDLE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a, r;
    repeat (3) step();

    // 1: reset values, then ID byte with exact latency
    push(K_XO, cyc, 8'h00, "reset_xo");
    push(K_IRQ, cyc, 8'h00, "reset_irq");
    push(K_MISC, cyc, 8'h00, "reset_misc");
    step();
    sys_rst = 1'b1;
    step();
    push(K_XO, cyc + 4, 8'h00, "id_early");
    rd(4'd0, 8'h50, "id_byte");
    XI_PRWA = A_IDLE;
    push(K_XO, cyc + 5, 8'h00, "id_late");
    step();

    // 2: scratch, misc, out-of-range scratch, unmapped sub-address, non-R_ID read
    wr(W_SCR_BASE + 1, 6'h2A);
    rd(4'd2, 8'h6A, "scr1_read");
    rd(4'd9, 8'h69, "sub9_default");
    XI_PRWA = A_IDLE;
    XI_PRdSubA = 4'd2;
    push(K_XO, cyc + 5, 8'h00, "non_rid_read");
    step();
    wr(W_SCR_BASE + 2, 6'h15);
    rd(4'd1, 8'h40, "scr0_untouched");
    rd(4'd2, 8'h6A, "scr1_untouched");
    push(K_MISC, cyc + 2, 8'h0C, "miscreg_lag");
    wr(W_MISC, 6'h3C);
    rd(4'd3, 8'h5C, "misc_read");

    // 3: mask, event edges, irq, W1C
    wr(W_MASK, 6'b000011);
    rd(4'd5, 8'h03, "mask_read");
    evt_in = 4'b0001;
    push(K_IRQ, cyc + 1, 8'h01, "irq_evt0");
    step();
    evt_in = 4'b0000;
    rd(S_STAT, 8'h01, "status_0001");
    evt_in = 4'b0100;
    push(K_IRQ, cyc + 1, 8'h01, "irq_evt2_masked");
    step();
    evt_in = 4'b0000;
    rd(S_STAT, 8'h05, "status_0101");
    push(K_IRQ, cyc + 1, 8'h00, "irq_after_w1c");
    wr(W_STATUS, 6'b000001);
    rd(S_STAT, 8'h04, "status_0100");

    // 4: rise beats same-cycle clear; held-high event does not re-set
    wr(W_STATUS, 6'h3F);
    XI_PWr = 1'b1;
    XI_PRWA = 4'(W_STATUS);
    XI_PD = 6'b000010;
    evt_in = 4'b0010;
    push(K_IRQ, cyc + 1, 8'h01, "irq_set_wins");
    step();
    XI_PWr = 1'b0;
    XI_PRWA = A_IDLE;
    rd(S_STAT, 8'h02, "status_set_wins");
    push(K_IRQ, cyc + 1, 8'h00, "irq_held_w1c");
    wr(W_STATUS, 6'b000010);
    push(K_IRQ, cyc + 2, 8'h00, "irq_held_no_reset");
    step();
    step();
    rd(S_STAT, 8'h00, "status_held_no_reset");
    evt_in = 4'b0000;

    // 5: read-to-clear with a bit rising between capture and PRdFinished
    wr(W_STATUS, 6'h3F);
    evt_in = 4'b0011;
    step();
    evt_in = 4'b0000;
    rd(S_STAT, 8'h03, "rdclr_snapshot");
    evt_in = 4'b1000;
    step();
    XI_PRdFinished = 1'b1;
    step();
    XI_PRdFinished = 1'b0;
    evt_in = 4'b0000;
    XI_PRWA = A_IDLE;
    step();
`ifdef PIFCTL_RDCLR_EN
    rd(S_STAT, 8'h08, "rdclr_result");
`else
    rd(S_STAT, 8'h0B, "no_rdclr_result");
`endif

    // 6: reset during a back-to-back read stream
    a = cyc;
    for (int i = 0; i < 8; i++) begin
      XI_PRWA = A_RID;
      XI_PRdSubA = 4'd0;
      if (i == 0) push(K_XO, a + 5, 8'h50, "stream_before_reset");
      step();
    end
    sys_rst = 1'b0;
    push(K_XO, cyc, 8'h00, "mid_reset_xo");
    push(K_MISC, cyc, 8'h00, "mid_reset_misc");
    push(K_IRQ, cyc, 8'h00, "mid_reset_irq");
    step();
    step();
    sys_rst = 1'b1;
    r = cyc;
    for (int i = 0; i < 5; i++) push(K_XO, r + i, 8'h00, "post_reset_quiet");
    push(K_XO, r + 5, 8'h50, "post_reset_first");
    repeat (8) step();

    for (int i = 0; i < 40 && sb.size() > 0; i++) step();
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s: never sampled, due cycle %0d", sb[0].name, sb[0].due);
      void'(sb.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
